// File: rtl/onchip_ram_pkg.sv
`default_nettype none
// ============================================================================
// onchip_ram_pkg : shared types, latency limits and width helpers
// Rev 1.0
// ============================================================================
package onchip_ram_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int MIN_LAT = 1;
    localparam int MAX_LAT = 2;

    function automatic int BE_W(input int data_w);
        return data_w / 8;
    endfunction

    // Stored lane: one data byte plus, when enabled, its even-parity bit.
    function automatic int LANE_W(input bit parity_en);
        return parity_en ? 9 : 8;
    endfunction

    function automatic int CLAMP_LAT(input int lat);
        return (lat >= MAX_LAT) ? MAX_LAT : MIN_LAT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/onchip_ram_tdp_core.sv
`default_nettype none
// ============================================================================
// onchip_ram_tdp_core : true-dual-port byte-lane RAM, old-data read semantics,
// optional output register. Rev 1.0
// ============================================================================
module onchip_ram_tdp_core #(
    parameter int LANE_W  = 8,
    parameter int LANES   = 4,
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int OUT_REG = 0
) (
    input  logic                      clk,
    input  logic                      ce,
    input  logic                      a_we,
    input  logic                      a_re,
    input  logic [AW-1:0]             a_addr,
    input  logic [LANES-1:0]          a_be,
    input  logic [LANE_W*LANES-1:0]   a_wdata,
    output logic [LANE_W*LANES-1:0]   a_q,
    input  logic                      b_we,
    input  logic                      b_re,
    input  logic [AW-1:0]             b_addr,
    input  logic [LANES-1:0]          b_be,
    input  logic [LANE_W*LANES-1:0]   b_wdata,
    output logic [LANE_W*LANES-1:0]   b_q
);

    localparam int W = LANE_W * LANES;

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] a_rd_q;
    logic [W-1:0] b_rd_q;

    // Reads sample the array before this edge's writes land: old data on collision.
    always_ff @(posedge clk) begin
        if (ce) begin
            if (a_re) a_rd_q <= mem_q[a_addr];
            if (b_re) b_rd_q <= mem_q[b_addr];
            for (int l = 0; l < LANES; l++) begin
                if (a_we && a_be[l]) mem_q[a_addr][l*LANE_W +: LANE_W] <= a_wdata[l*LANE_W +: LANE_W];
                if (b_we && b_be[l]) mem_q[b_addr][l*LANE_W +: LANE_W] <= b_wdata[l*LANE_W +: LANE_W];
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [W-1:0] a_out_q;
        logic [W-1:0] b_out_q;
        always_ff @(posedge clk) begin
            if (ce) begin
                a_out_q <= a_rd_q;
                b_out_q <= b_rd_q;
            end
        end
        assign a_q = a_out_q;
        assign b_q = b_out_q;
    end else begin : g_no_out_reg
        assign a_q = a_rd_q;
        assign b_q = b_rd_q;
    end

endmodule
`default_nettype wire

// File: rtl/onchip_ram_dp_avmm.sv
`default_nettype none
// ============================================================================
// onchip_ram_dp_avmm : dual Avalon-MM port on-chip RAM with post-reset clear.
// Optional parity via macro ONCHIP_RAM_PARITY_EN.  Rev 1.0
// ============================================================================
module onchip_ram_dp_avmm
    import onchip_ram_pkg::*;
#(
    parameter int    DATA_W         = 32,
    parameter int    ADDR_W         = 15,
    parameter int    DEPTH          = 25600,
    parameter int    READ_LATENCY   = 1,
    parameter int    CLEAR_ON_RESET = 1,
    parameter string INIT_FILE      = "onchip_ram.hex"
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reset_req,
    input  logic                   clken,
    input  logic [ADDR_W-1:0]      s1_address,
    input  logic                   s1_chipselect,
    input  logic                   s1_read,
    input  logic                   s1_write,
    input  logic [DATA_W-1:0]      s1_writedata,
    input  logic [DATA_W/8-1:0]    s1_byteenable,
    output logic                   s1_waitrequest,
    output logic [DATA_W-1:0]      s1_readdata,
    output logic                   s1_readdatavalid,
    output logic                   s1_parity_err,
    input  logic [ADDR_W-1:0]      s2_address,
    input  logic                   s2_chipselect,
    input  logic                   s2_read,
    input  logic                   s2_write,
    input  logic [DATA_W-1:0]      s2_writedata,
    input  logic [DATA_W/8-1:0]    s2_byteenable,
    output logic                   s2_waitrequest,
    output logic [DATA_W-1:0]      s2_readdata,
    output logic                   s2_readdatavalid,
    output logic                   s2_parity_err,
    output logic                   busy,
    output logic                   parity_err_sticky
);

    localparam int BW  = BE_W(DATA_W);
`ifdef ONCHIP_RAM_PARITY_EN
    localparam int LW  = LANE_W(1'b1);
`else
    localparam int LW  = LANE_W(1'b0);
`endif
    localparam int EW  = LW * BW;
    localparam int LAT = CLAMP_LAT(READ_LATENCY);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Without an init image there is nothing to preserve, so clear anyway.
    localparam bit DO_CLEAR = (CLEAR_ON_RESET != 0) || (INIT_FILE == "");
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [AW-1:0]   LAST_C   = AW'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [AW-1:0]     clr_addr_q, clr_addr_d;
    logic              w_wait;

    logic [1:0]                   w_cs, w_rd, w_wr, w_acc_rd, w_acc_wr, w_inr, w_vld, w_perr;
    logic [1:0][ADDR_W-1:0]       w_addr;
    logic [1:0][DATA_W-1:0]       w_wd, w_rdata;
    logic [1:0][BW-1:0]           w_be;
    logic [1:0][EW-1:0]           w_enc, w_q;
    logic                         w_collide;

    assign w_cs   = {s2_chipselect, s1_chipselect};
    assign w_rd   = {s2_read, s1_read};
    assign w_wr   = {s2_write, s1_write};
    assign w_addr = {s2_address, s1_address};
    assign w_wd   = {s2_writedata, s1_writedata};
    assign w_be   = {s2_byteenable, s1_byteenable};

    // ---------------- clear engine ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DO_CLEAR ? ST_CLEAR : ST_READY;
            clr_addr_q <= '0;
        end else if (clken) begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == ST_CLEAR) begin
            if (clr_addr_q == LAST_C) state_d    = ST_READY;
            else                      clr_addr_d = clr_addr_q + 1'b1;
        end
    end

    assign busy           = (state_q == ST_CLEAR);
    assign w_wait         = busy | ~clken | reset_req;
    assign s1_waitrequest = w_wait;
    assign s2_waitrequest = w_wait;

    // Same-address double write: s1 owns the word, s2 is dropped entirely.
    assign w_collide = w_acc_wr[0] & w_acc_wr[1] & w_inr[0] & w_inr[1] & (w_addr[0] == w_addr[1]);

    onchip_ram_tdp_core #(
        .LANE_W (LW),
        .LANES  (BW),
        .DEPTH  (DEPTH),
        .AW     (AW),
        .OUT_REG((LAT == MAX_LAT) ? 1 : 0)
    ) u_core (
        .clk    (clk),
        .ce     (clken),
        .a_we   (busy | (w_acc_wr[0] & w_inr[0])),
        .a_re   (w_acc_rd[0] & w_inr[0]),
        .a_addr (busy ? clr_addr_q : w_addr[0][AW-1:0]),
        .a_be   (busy ? {BW{1'b1}} : w_be[0]),
        .a_wdata(busy ? {EW{1'b0}} : w_enc[0]),
        .a_q    (w_q[0]),
        .b_we   (w_acc_wr[1] & w_inr[1] & ~w_collide),
        .b_re   (w_acc_rd[1] & w_inr[1]),
        .b_addr (w_addr[1][AW-1:0]),
        .b_be   (w_be[1]),
        .b_wdata(w_enc[1]),
        .b_q    (w_q[1])
    );

    // ---------------- per-port handshake and read return ----------------
    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [LAT-1:0]    vld_q, rok_q;
        logic [DATA_W-1:0] hold_q, w_dat;

        assign w_acc_rd[p] = w_cs[p] & w_rd[p] & ~w_wr[p] & ~w_wait;
        assign w_acc_wr[p] = w_cs[p] & w_wr[p] & ~w_wait;
        assign w_inr[p]    = {1'b0, w_addr[p]} < DEPTH_C;

        always_ff @(posedge clk) begin
            if (reset) begin
                vld_q <= '0;
                rok_q <= '0;
            end else if (clken) begin
                vld_q[0] <= w_acc_rd[p];
                rok_q[0] <= w_inr[p];
                for (int i = 1; i < LAT; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    rok_q[i] <= rok_q[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) hold_q <= '0;
            else       hold_q <= w_rdata[p];
        end

        assign w_vld[p]   = vld_q[LAT-1];
        assign w_rdata[p] = w_vld[p] ? (rok_q[LAT-1] ? w_dat : {DATA_W{1'b0}}) : hold_q;

`ifdef ONCHIP_RAM_PARITY_EN
        logic [BW-1:0] w_perr_lane;
        for (genvar l = 0; l < BW; l++) begin : g_lane
            assign w_enc[p][l*LW +: LW] = {^w_wd[p][l*8 +: 8], w_wd[p][l*8 +: 8]};
            assign w_dat[l*8 +: 8]      = w_q[p][l*LW +: 8];
            assign w_perr_lane[l]       = ^w_q[p][l*LW +: LW];
        end
        assign w_perr[p] = w_vld[p] & rok_q[LAT-1] & (|w_perr_lane);
`else
        assign w_enc[p]  = w_wd[p];
        assign w_dat     = w_q[p];
        assign w_perr[p] = 1'b0;
`endif
    end

`ifdef ONCHIP_RAM_PARITY_EN
    logic sticky_q;
    always_ff @(posedge clk) begin
        if (reset)        sticky_q <= 1'b0;
        else if (|w_perr) sticky_q <= 1'b1;
    end
    assign parity_err_sticky = sticky_q;
`else
    assign parity_err_sticky = 1'b0;
`endif

    assign s1_readdata      = w_rdata[0];
    assign s2_readdata      = w_rdata[1];
    assign s1_readdatavalid = w_vld[0];
    assign s2_readdatavalid = w_vld[1];
    assign s1_parity_err    = w_perr[0];
    assign s2_parity_err    = w_perr[1];

endmodule
`default_nettype wire

// File: tb/tb_onchip_ram_dp_avmm.sv
`default_nettype none
// ============================================================================
// tb_onchip_ram_dp_avmm : directed bench, DEPTH=16, READ_LATENCY=2. Rev 1.0
// ============================================================================
module tb_onchip_ram_dp_avmm;

    localparam int DW = 32;
    localparam int AWD = 5;

    logic clk = 1'b0;
    logic reset, reset_req, clken;
    logic [AWD-1:0] s1_address, s2_address;
    logic s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
    logic [DW-1:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
    logic [3:0] s1_byteenable, s2_byteenable;
    logic s1_waitrequest, s2_waitrequest, s1_readdatavalid, s2_readdatavalid;
    logic s1_parity_err, s2_parity_err, busy, parity_err_sticky;

    int n_cmp = 0;
    int n_err = 0;

    logic [AWD-1:0] ba [4] = '{5'd5, 5'd0, 5'd5, 5'd1};
    logic [DW-1:0]  be_exp [4] = '{32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};

    onchip_ram_dp_avmm #(
        .DATA_W(DW), .ADDR_W(AWD), .DEPTH(16), .READ_LATENCY(2),
        .CLEAR_ON_RESET(1), .INIT_FILE("")
    ) dut (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable),
        .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
        .s1_readdatavalid(s1_readdatavalid), .s1_parity_err(s1_parity_err),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_writedata(s2_writedata), .s2_byteenable(s2_byteenable),
        .s2_waitrequest(s2_waitrequest), .s2_readdata(s2_readdata),
        .s2_readdatavalid(s2_readdatavalid), .s2_parity_err(s2_parity_err),
        .busy(busy), .parity_err_sticky(parity_err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
        s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
    endtask

    task automatic set_port(input int p, input logic rd, input logic wr,
                            input logic [AWD-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        if (p == 1) begin
            s1_chipselect = rd | wr; s1_read = rd; s1_write = wr;
            s1_address = a; s1_writedata = d; s1_byteenable = be;
        end else begin
            s2_chipselect = rd | wr; s2_read = rd; s2_write = wr;
            s2_address = a; s2_writedata = d; s2_byteenable = be;
        end
    endtask

    function automatic logic get_vld(input int p);
        return (p == 1) ? s1_readdatavalid : s2_readdatavalid;
    endfunction

    function automatic logic [DW-1:0] get_data(input int p);
        return (p == 1) ? s1_readdata : s2_readdata;
    endfunction

    function automatic logic get_perr(input int p);
        return (p == 1) ? s1_parity_err : s2_parity_err;
    endfunction

    task automatic wr(input int p, input logic [AWD-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        set_port(p, 1'b0, 1'b1, a, d, be);
        tick();
        idle();
    endtask

    task automatic rd(input int p, input logic [AWD-1:0] a, input logic [DW-1:0] exp);
        set_port(p, 1'b1, 1'b0, a, '0, 4'h0);
        tick();
        idle();
        check($sformatf("rd%0d@%0d early valid", p, a), 32'(get_vld(p)), 32'd0);
        tick();
        check($sformatf("rd%0d@%0d valid", p, a), 32'(get_vld(p)), 32'd1);
        check($sformatf("rd%0d@%0d data", p, a), get_data(p), exp);
        check($sformatf("rd%0d@%0d perr", p, a), 32'(get_perr(p)), 32'd0);
    endtask

    task automatic count_busy(input string tag);
        int n;
        logic wr_ok;
        n = 0;
        wr_ok = 1'b1;
        while (busy === 1'b1 && n < 40) begin
            wr_ok = wr_ok & s1_waitrequest & s2_waitrequest;
            tick();
            n++;
        end
        check({tag, " busy cycles"}, 32'(n), 32'd16);
        check({tag, " waitreq while busy"}, 32'(wr_ok), 32'd1);
        check({tag, " waitreq after clear"}, 32'(s1_waitrequest), 32'd0);
    endtask

    initial begin
        reset = 1'b1; reset_req = 1'b0; clken = 1'b1;
        s1_address = '0; s2_address = '0; s1_writedata = '0; s2_writedata = '0;
        s1_byteenable = '0; s2_byteenable = '0;
        idle();
        repeat (3) tick();

        // Reset state
        check("reset busy", 32'(busy), 32'd1);
        check("reset s1 valid", 32'(s1_readdatavalid), 32'd0);
        check("reset s2 valid", 32'(s2_readdatavalid), 32'd0);
        check("reset s1 rdata", s1_readdata, 32'h0);
        check("reset s2 rdata", s2_readdata, 32'h0);
        check("reset waitreq", 32'(s2_waitrequest), 32'd1);
        check("reset sticky", 32'(parity_err_sticky), 32'd0);

        // 1. Clear after reset
        reset = 1'b0;
        count_busy("clear");
        for (int a = 0; a < 16; a++) rd(1, AWD'(a), 32'h0);
        rd(2, 5'd15, 32'h0);

        // 2. Latency 2 and back-to-back reads
        wr(1, 5'd5, 32'hDEADBEEF, 4'hF);
        rd(1, 5'd5, 32'hDEADBEEF);
        set_port(1, 1'b1, 1'b0, ba[0], '0, 4'h0);
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c < 3) set_port(1, 1'b1, 1'b0, ba[c+1], '0, 4'h0);
            else       idle();
            if (c >= 1 && c <= 4) begin
                check($sformatf("burst c%0d valid", c), 32'(s1_readdatavalid), 32'd1);
                check($sformatf("burst c%0d data", c), s1_readdata, be_exp[c-1]);
            end else begin
                check($sformatf("burst c%0d idle", c), 32'(s1_readdatavalid), 32'd0);
            end
        end

        // 3. Byte enables
        wr(1, 5'd3, 32'h11223344, 4'hF);
        wr(1, 5'd3, 32'hAABBCCDD, 4'b0101);
        rd(1, 5'd3, 32'h11BB33DD);
        rd(2, 5'd3, 32'h11BB33DD);

        // 4. Collisions
        set_port(1, 1'b0, 1'b1, 5'd7, 32'h1, 4'hF);
        set_port(2, 1'b0, 1'b1, 5'd7, 32'h2, 4'hF);
        tick();
        idle();
        rd(1, 5'd7, 32'h1);
        set_port(1, 1'b0, 1'b1, 5'd7, 32'h9, 4'hF);
        set_port(2, 1'b1, 1'b0, 5'd7, '0, 4'h0);
        tick();
        idle();
        tick();
        check("xport s2 valid", 32'(s2_readdatavalid), 32'd1);
        check("xport s2 old data", s2_readdata, 32'h1);
        rd(2, 5'd7, 32'h9);
        set_port(1, 1'b0, 1'b1, 5'd8, 32'hA5A5A5A5, 4'hF);
        set_port(2, 1'b0, 1'b1, 5'd9, 32'h5A5A5A5A, 4'hF);
        tick();
        idle();
        rd(2, 5'd8, 32'hA5A5A5A5);
        rd(1, 5'd9, 32'h5A5A5A5A);

        // 5a. clken stall mid-read
        set_port(1, 1'b1, 1'b0, 5'd3, '0, 4'h0);
        tick();
        idle();
        clken = 1'b0;
        #1;
        check("stall waitreq s1", 32'(s1_waitrequest), 32'd1);
        check("stall waitreq s2", 32'(s2_waitrequest), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall %0d valid", i), 32'(s1_readdatavalid), 32'd0);
        end
        clken = 1'b1;
        tick();
        check("stall late valid", 32'(s1_readdatavalid), 32'd1);
        check("stall data", s1_readdata, 32'h11BB33DD);
        tick();
        check("post valid low", 32'(s1_readdatavalid), 32'd0);
        check("readdata hold", s1_readdata, 32'h11BB33DD);

        // 5b. Out-of-range
        rd(1, 5'd16, 32'h0);
        wr(1, 5'd16, 32'hFFFFFFFF, 4'hF);
        rd(1, 5'd0, 32'h0);
        rd(2, 5'd31, 32'h0);

        // reset_req blocks transfers
        reset_req = 1'b1;
        #1;
        check("reset_req waitreq s1", 32'(s1_waitrequest), 32'd1);
        check("reset_req waitreq s2", 32'(s2_waitrequest), 32'd1);
        wr(1, 5'd4, 32'h12345678, 4'hF);
        reset_req = 1'b0;
        rd(1, 5'd4, 32'h0);

        // Reset flushes an in-flight read
        set_port(1, 1'b1, 1'b0, 5'd5, '0, 4'h0);
        tick();
        idle();
        reset = 1'b1;
        tick();
        check("flush valid", 32'(s1_readdatavalid), 32'd0);
        check("flush rdata", s1_readdata, 32'h0);

        // 5c. Reset at clear count 8 restarts the sweep
        reset = 1'b0;
        repeat (8) tick();
        check("mid-clear busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_busy("reclear");
        rd(1, 5'd5, 32'h0);
        rd(2, 5'd3, 32'h0);
        check("sticky idle", 32'(parity_err_sticky), 32'd0);

`ifdef ONCHIP_RAM_PARITY_EN
        // 6. Parity
        wr(1, 5'd2, 32'h000000F0, 4'hF);
        dut.u_core.mem_q[2][0] = ~dut.u_core.mem_q[2][0];
        set_port(1, 1'b1, 1'b0, 5'd2, '0, 4'h0);
        tick();
        idle();
        tick();
        check("par valid", 32'(s1_readdatavalid), 32'd1);
        check("par err pulse", 32'(s1_parity_err), 32'd1);
        check("par sticky", 32'(parity_err_sticky), 32'd1);
        tick();
        check("par err drop", 32'(s1_parity_err), 32'd0);
        check("par sticky hold", 32'(parity_err_sticky), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("par sticky reset", 32'(parity_err_sticky), 32'd0);
        count_busy("par clear");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/onchip_ram_dp_avmm.md
Name: onchip_ram_dp_avmm

Overview:
Parametrised true-dual-port on-chip RAM with two independent Avalon-MM slave ports (s1, s2). It is the next generation of the single-port onchip_memory2 block used by the Nios subsystem.
- Adds configurable width, depth and read latency.
- Adds readdatavalid/waitrequest handshakes.
- Adds a post-reset memory clear engine.
- Adds defined collision behaviour.
Sits on the Nios data/instruction interconnect; s2 is typically used by a DMA or HPS bridge.

Parameters:
DATA_W, 32, word width in bits (multiple of 8)
ADDR_W, 15, word-address width of each port
DEPTH, 25600, number of words (≤ 2**ADDR_W)
READ_LATENCY, 1, read latency in cycles: 1 = unregistered q, 2 = registered q
CLEAR_ON_RESET, 1, 1 = zero whole array after reset; 0 = keep INIT_FILE contents
INIT_FILE, "onchip_ram.hex", initial contents at configuration

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
reset_req  in  1  reset pending; blocks new transfers on both ports
clken  in  1  global clock enable; 0 stalls everything
s1_address / s2_address  in  ADDR_W  word address
s1_chipselect / s2_chipselect  in  1  port select
s1_read / s2_read  in  1  read request
s1_write / s2_write  in  1  write request
s1_writedata / s2_writedata  in  DATA_W  write data
s1_byteenable / s2_byteenable  in  DATA_W/8  byte lane enables
s1_waitrequest / s2_waitrequest  out  1  transfer not accepted this cycle
s1_readdata / s2_readdata  out  DATA_W  read data
s1_readdatavalid / s2_readdatavalid  out  1  readdata valid strobe
busy  out  1  clear engine active

Behaviour:
- Reset behaviour (reset high at a clk edge):
  - readdatavalid pipelines flushed to 0; readdata = 0.
  - FSM goes to CLEAR if CLEAR_ON_RESET = 1, else READY.
  - Clear address counter set to 0.
- FSM states:
  - CLEAR: writes 0 with all byte lanes to counter address via port A, one word per cycle while clken = 1.
  - CLEAR → READY after address DEPTH-1 has been written, i.e. DEPTH enabled cycles.
  - busy = 1 throughout CLEAR.
  - reset asserted during CLEAR restarts the counter at 0.
- waitrequest:
  - sX_waitrequest = busy | ~clken | reset_req, in all states (combinational).
  - Each port has its own waitrequest.
- Transfer acceptance:
  - Accepted when chipselect & (read | write) & ~waitrequest.
  - read and write both high: treated as write only, no readdatavalid.
- Reads:
  - readdatavalid pulses exactly READ_LATENCY cycles after acceptance.
  - Pipelined: one read per cycle per port.
  - When clken = 0, the read pipeline and readdatavalid pipeline both hold.
- Writes:
  - Only enabled byte lanes are updated.
  - Write data is visible to a read accepted on the following cycle.
- Out-of-range address (≥ DEPTH):
  - Writes are dropped.
  - Reads complete normally with readdata = 0.
- Same-cycle, same-address events:
  - Read-during-write on the same port returns old data.
  - Mixed port (one writes, the other reads) returns old data.
  - Both ports write: s1 wins; s2 write is suppressed for the whole word.
- readdata: holds its last value when readdatavalid = 0.

Optional Feature:
Macro ONCHIP_RAM_PARITY_EN.
- Defined:
  - Stores one even-parity bit per byte, computed on write (and on clear).
  - On each read, stored parity is checked against the data.
  - Any mismatch pulses sX_parity_err together with sX_readdatavalid.
  - A sticky parity_err_sticky output is set on any mismatch and cleared by reset.
- Undefined:
  - No parity storage.
  - sX_parity_err and parity_err_sticky are still present, tied to 0.

Decomposition:
- Package onchip_ram_pkg:
  - FSM state enum (ST_CLEAR, ST_READY).
  - Latency limits: MIN_LAT = 1, MAX_LAT = 2.
  - Function BE_W(DATA_W) = DATA_W/8.
  - Parity-width helper.
- Sub-module onchip_ram_tdp_core:
  - Inferred true-dual-port byte-enabled array with old-data read semantics and optional output register.
- Top level holds the clear FSM, collision masking, range check and valid pipelines.

Test Plan:
1. Clear after reset: CLEAR_ON_RESET = 1, DEPTH = 16, deassert reset → busy and waitrequest high for exactly 16 cycles; then reads of addresses 0..15 all return 0x00000000.
2. Read latency: READ_LATENCY = 2, write 0xDEADBEEF @5 via s1, then read @5 → s1_readdatavalid exactly 2 cycles after acceptance with 0xDEADBEEF; 4 back-to-back reads give 4 consecutive valids.
3. Byte enables: write 0x11223344 @3, then 0xAABBCCDD with be = 4'b0101 → read @3 = 0x11BB33DD.
4. Write collision: s1 and s2 write 0x1 and 0x2 @7 in the same cycle → read @7 = 0x00000001. Concurrent s1 write 0x9 and s2 read @7 → s2 returns old value.
5. Stalls and range: clken = 0 for 3 cycles mid-read → valid is delayed by 3 with data unchanged; read @DEPTH returns 0 with valid; reset pulsed at clear count 8 → busy lasts a full DEPTH cycles after reset release.
6. Parity (ONCHIP_RAM_PARITY_EN): force-flip one stored bit @2, read @2 → s1_parity_err pulses with valid; parity_err_sticky = 1 until reset.
